// File: rtl/pbit_pkg.sv
// pbit_pkg: Q4.2 format defaults, saturation limits, LFSR taps and the
// sign-magnitude helpers used by pbit_node.
package pbit_pkg;

    localparam int PBIT_N = 7;
    localparam int PBIT_Q = 2;

    // Sign-magnitude working width: 1 sign + (N+1) magnitude bits.
    localparam int SM_W = PBIT_N + 1;

    localparam logic [PBIT_N-1:0] SAT_NEG = 7'b1100000;
    localparam logic [PBIT_N-1:0] SAT_POS = 7'b0011111;

    // x^32 + x^22 + x^2 + x + 1, taps at bits 31, 21, 1, 0
    localparam logic [31:0] LFSR_TAPS     = 32'h8020_0003;
    localparam logic [31:0] LFSR_DEF_SEED = 32'h0000_0001;

    localparam logic [SM_W-1:0] SM_ONE = SM_W'(1);

    typedef struct packed {
        logic            sgn;
        logic [SM_W-1:0] mag;
    } sm_t;

    function automatic sm_t sm_norm(input sm_t a);
        sm_t res;
        res = a;
        if (a.mag == '0)
            res.sgn = 1'b0;
        return res;
    endfunction

    function automatic sm_t sm_mul_spin(input sm_t w, input logic s);
        sm_t res;
        res.mag = w.mag;
        res.sgn = w.sgn ^ ~s;
        return sm_norm(res);
    endfunction

    function automatic sm_t sm_add(input sm_t a, input sm_t b);
        sm_t res;
        if (a.sgn == b.sgn) begin
            res.sgn = a.sgn;
            res.mag = a.mag + b.mag;
        end else if (a.mag >= b.mag) begin
            res.sgn = a.sgn;
            res.mag = a.mag - b.mag;
        end else begin
            res.sgn = b.sgn;
            res.mag = b.mag - a.mag;
        end
        return sm_norm(res);
    endfunction

    // lim is the magnitude of the most negative code (8.0 in LSBs)
    function automatic sm_t sm_sat(input sm_t z, input logic [SM_W-1:0] lim);
        sm_t res;
        res = z;
        if (z.sgn && (z.mag > lim))
            res.mag = lim;
        else if (!z.sgn && (z.mag >= lim))
            res.mag = lim - SM_ONE;
        return res;
    endfunction

    function automatic logic signed [SM_W:0] sm_to_tc(input sm_t z);
        logic signed [SM_W:0] m;
        m = $signed({1'b0, z.mag});
        return z.sgn ? -m : m;
    endfunction

    function automatic logic [31:0] lfsr_seed(input logic [31:0] init);
        return (init == '0) ? LFSR_DEF_SEED : init;
    endfunction

endpackage

// File: rtl/pbit_lfsr.sv
// pbit_lfsr: free-running 32-bit Fibonacci LFSR; low five bits give the
// signed random sample r used by the p-bit comparator.
module pbit_lfsr
    import pbit_pkg::*;
#(
    parameter logic [31:0] INIT = 32'h1
) (
    input  logic              CLK,
    input  logic              RST,
    output logic signed [4:0] r
);

    logic [31:0] state;
    logic        fb;

    assign fb = ^(state & LFSR_TAPS);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state <= lfsr_seed(INIT);
        else
            state <= {state[30:0], fb};
    end

    assign r = state[4:0];

endmodule

// File: rtl/pbit_node.sv
// pbit_node: probabilistic bit, pbit_val <= (sat(w_a*s_a + w_b*s_b + bias) > r).
// Define PBIT_DBG_EN to expose z_dbg / r_dbg.
module pbit_node
    import pbit_pkg::*;
#(
    parameter int          N    = PBIT_N,
    parameter int          Q    = PBIT_Q,
    parameter logic [31:0] INIT = 32'h1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         en,
    input  logic         s_a,
    input  logic         s_b,
    input  logic [N-1:0] w_a,
    input  logic [N-1:0] w_b,
    input  logic [N-1:0] bias,
    output logic         pbit_val
`ifdef PBIT_DBG_EN
    ,
    output logic [N-1:0] z_dbg,
    output logic [4:0]   r_dbg
`endif
);

    localparam int SAT_LIM = 8 << Q;

    sm_t wa_sm;
    sm_t wb_sm;
    sm_t bias_sm;
    sm_t prod_a;
    sm_t prod_b;
    sm_t z_raw;
    sm_t z_sat;

    logic signed [SM_W:0] zc;
    logic signed [SM_W:0] r_ext;
    logic signed [4:0]    r;

    assign wa_sm   = {w_a[N-1], SM_W'(w_a[N-2:0])};
    assign wb_sm   = {w_b[N-1], SM_W'(w_b[N-2:0])};
    assign bias_sm = {bias[N-1], SM_W'(bias[N-2:0])};

    // The N+2 bit sum cannot overflow, so saturation sees the true value.
    always_comb begin
        prod_a = sm_mul_spin(wa_sm, s_a);
        prod_b = sm_mul_spin(wb_sm, s_b);
        z_raw  = sm_add(sm_add(prod_a, prod_b), bias_sm);
        z_sat  = sm_sat(z_raw, SM_W'(SAT_LIM));
        zc     = sm_to_tc(z_sat);
    end

    pbit_lfsr #(
        .INIT (INIT)
    ) u_lfsr (
        .CLK (CLK),
        .RST (RST),
        .r   (r)
    );

    assign r_ext = (SM_W+1)'(r);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            pbit_val <= 1'b0;
        else if (en)
            pbit_val <= (zc > r_ext);
    end

`ifdef PBIT_DBG_EN
    assign z_dbg = {z_sat.sgn, z_sat.mag[N-2:0]};
    assign r_dbg = r;
`endif

endmodule

// File: tb/tb_pbit_node.sv
// tb_pbit_node: directed checks of pbit_node against hand-computed z values
// and an independent LFSR reference.
module tb_pbit_node;

    logic       CLK = 1'b0;
    logic       RST;
    logic       en;
    logic       s_a;
    logic       s_b;
    logic [6:0] w_a;
    logic [6:0] w_b;
    logic [6:0] bias;
    logic       pbit_val;
`ifdef PBIT_DBG_EN
    logic [6:0] z_dbg;
    logic [4:0] r_dbg;
`endif

    int total = 0;
    int fails = 0;
    int ones;
    int zc_exp;

    logic [31:0] lfsr_m;
    logic        exp_q;

    always #5 CLK = ~CLK;

    pbit_node #(
        .N    (7),
        .Q    (2),
        .INIT (32'h1)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .en       (en),
        .s_a      (s_a),
        .s_b      (s_b),
        .w_a      (w_a),
        .w_b      (w_b),
        .bias     (bias),
        .pbit_val (pbit_val)
`ifdef PBIT_DBG_EN
        ,
        .z_dbg    (z_dbg),
        .r_dbg    (r_dbg)
`endif
    );

    // Reference: seed 1, taps 32/22/2/1, r = signed low five bits.
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            lfsr_m <= 32'h1;
            exp_q  <= 1'b0;
        end else begin
            if (en)
                exp_q <= (zc_exp > $signed({{27{lfsr_m[4]}}, lfsr_m[4:0]}));
            lfsr_m <= {lfsr_m[30:0], lfsr_m[31] ^ lfsr_m[21] ^ lfsr_m[1] ^ lfsr_m[0]};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic check_rng(input string tag, input int got, input int lo, input int hi);
        total++;
        assert (got >= lo && got <= hi) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, got, lo, hi);
        end
    endtask

    task automatic apply(input logic [6:0] wa, input logic [6:0] wb, input logic [6:0] b,
                         input logic sa, input logic sb, input int zc);
        w_a    = wa;
        w_b    = wb;
        bias   = b;
        s_a    = sa;
        s_b    = sb;
        zc_exp = zc;
    endtask

    task automatic sample_model(input int n, input string tag);
        ones = 0;
        en   = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            check(tag, 32'(pbit_val), 32'(exp_q));
            if (pbit_val === 1'b1)
                ones++;
        end
        en = 1'b0;
    endtask

    task automatic sample_const(input int n, input string tag, input logic want);
        en = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            check(tag, 32'(pbit_val), 32'(want));
        end
        en = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        en  = 1'b0;
        apply(7'b0, 7'b0, 7'b0, 1'b1, 1'b1, 0);
        @(negedge CLK);
        @(negedge CLK);
        check("reset", 32'(pbit_val), 32'h0);

        // first enabled edge after release uses seed r = +1: strict compare
        RST = 1'b0;
        apply(7'b0000001, 7'b0, 7'b0, 1'b1, 1'b1, 1);
        sample_const(1, "seed_eq", 1'b0);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        apply(7'b0000010, 7'b0, 7'b0, 1'b1, 1'b1, 2);
        sample_const(1, "seed_gt", 1'b1);

        apply(7'b0001000, 7'b0001000, 7'b0000100, 1'b1, 1'b1, 20);
        sample_const(1000, "pos_strong", 1'b1);
        apply(7'b0001000, 7'b0001000, 7'b1000100, 1'b0, 1'b0, -20);
        sample_const(1000, "neg_strong", 1'b0);

        apply(7'b0001000, 7'b0001000, 7'b0000100, 1'b1, 1'b1, 20);
        sample_const(5, "pre_rst", 1'b1);
        #2 RST = 1'b1;
        #1 check("rst_async", 32'(pbit_val), 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("rst_hold", 32'(pbit_val), 32'h0);
        end

        apply(7'b0111111, 7'b0111111, 7'b0, 1'b1, 1'b1, 31);
        sample_const(64, "sat_pos", 1'b1);
`ifdef PBIT_DBG_EN
        check("zdbg_sat_pos", 32'(z_dbg), 32'h1F);
`endif
        apply(7'b0111111, 7'b0111111, 7'b0, 1'b0, 1'b0, -32);
        sample_const(64, "sat_neg", 1'b0);
`ifdef PBIT_DBG_EN
        check("zdbg_sat_neg", 32'(z_dbg), 32'h60);
`endif
        apply(7'b0010000, 7'b0010000, 7'b0, 1'b1, 1'b1, 31);
        sample_const(64, "pos_8p0", 1'b1);
`ifdef PBIT_DBG_EN
        check("zdbg_pos_8p0", 32'(z_dbg), 32'h1F);
`endif
        apply(7'b0010000, 7'b0010000, 7'b0, 1'b0, 1'b0, -32);
        sample_const(64, "neg_8p0", 1'b0);
        apply(7'b0010000, 7'b0010000, 7'b1000001, 1'b0, 1'b0, -32);
        sample_const(64, "neg_8p25", 1'b0);
`ifdef PBIT_DBG_EN
        check("zdbg_neg_8p25", 32'(z_dbg), 32'h60);
`endif

        apply(7'b0000011, 7'b1000001, 7'b0000001, 1'b1, 1'b0, 5);
        sample_model(128, "mix_pos");
        apply(7'b0001100, 7'b1000010, 7'b0000001, 1'b0, 1'b0, -9);
        sample_model(128, "mix_neg");
`ifdef PBIT_DBG_EN
        check("zdbg_mix_neg", 32'(z_dbg), 32'h49);
`endif
        apply(7'b0000100, 7'b0000100, 7'b1000000, 1'b1, 1'b0, 0);
        sample_model(128, "neg_zero");
`ifdef PBIT_DBG_EN
        check("zdbg_neg_zero", 32'(z_dbg), 32'h00);
`endif

        apply(7'b0, 7'b0, 7'b0, 1'b1, 1'b1, 0);
        sample_model(4096, "stat_z0");
        check_rng("stat_z0_ones", ones, 1898, 2198);
        apply(7'b0001000, 7'b0, 7'b0, 1'b1, 1'b1, 8);
        sample_model(4096, "stat_z2");
        check_rng("stat_z2_ones", ones, 2942, 3202);

        apply(7'b0001000, 7'b0001000, 7'b1000100, 1'b0, 1'b0, -20);
        sample_const(1, "hold_pre", 1'b0);
        apply(7'b0001000, 7'b0001000, 7'b0000100, 1'b1, 1'b1, 20);
        for (int i = 0; i < 50; i++) begin
            s_a = ~s_a;
            @(negedge CLK);
            check("hold", 32'(pbit_val), 32'h0);
        end
        s_a = 1'b1;
        sample_const(1, "pulse", 1'b1);
        apply(7'b0001000, 7'b0001000, 7'b1000100, 1'b0, 1'b0, -20);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check("post_pulse", 32'(pbit_val), 32'h1);
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
